oversample_cdr: RTL and testbench



---
 rtl/oversample_pkg.sv | 38 +++
 rtl/oversample_cdr_lane.sv | 175 +++++++++++++++++
 rtl/oversample_cdr.sv | 70 +++++++
 tb/tb_oversample_cdr.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/oversample_pkg.sv
// Shared definitions for the oversampled CDR back end.
//   OS_RATIO  : samples per UI delivered by the front end
//   phase_t   : sampling phase index 0..OS_RATIO-1
//   CNT_*     : encoding of the per-channel "bits valid" output
//   phase_step: turns an eye-centre target and the current phase into a step
package oversample_pkg;

  localparam int unsigned OS_RATIO = 8;
  localparam int unsigned PH_W     = 3;

  typedef logic [PH_W-1:0] phase_t;

  localparam logic [1:0] CNT_NONE = 2'd0;
  localparam logic [1:0] CNT_ONE  = 2'd1;
  localparam logic [1:0] CNT_TWO  = 2'd2;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  // Forward distance 1..half a UI steps up, anything further steps down.
  function automatic step_e phase_step(input phase_t target, input phase_t k);
    phase_t diff;
    step_e  st;
    diff = target - k;
    if (diff == '0) begin
      st = STEP_HOLD;
    end else if (diff <= phase_t'(OS_RATIO / 2)) begin
      st = STEP_UP;
    end else begin
      st = STEP_DOWN;
    end
    return st;
  endfunction

endpackage

// File: rtl/oversample_cdr_lane.sv
// One CDR channel: inversion fix-up, transition histogram, phase/lock
// tracking and bit output with wrap handling.
// Ports:
//   c, r      clock, synchronous active-high reset
//   wend      high on the clock after the shared window counter hits all ones
//   os        8 raw samples, bit 7 earliest, odd-numbered samples inverted
//   force_en, force_k  (only with OVERSAMPLE_CDR_FORCE_PHASE_EN) phase override
//   dat, cnt  recovered bits (dat[1] older) and number of valid bits
//   locked    phase stable for LOCK_WINDOWS windows
module oversample_cdr_lane
  import oversample_pkg::*;
#(
  parameter int unsigned WIN_LOG2     = 8,
  parameter int unsigned MIN_EDGES    = 16,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic       c,
  input  logic       r,
  input  logic       wend,
  input  logic [7:0] os,
`ifdef OVERSAMPLE_CDR_FORCE_PHASE_EN
  input  logic       force_en,
  input  logic [2:0] force_k,
`endif
  output logic [1:0] dat,
  output logic [1:0] cnt,
  output logic       locked
);

  localparam int unsigned HW = WIN_LOG2 + 1;
  localparam int unsigned TW = HW + 3;
  localparam int unsigned SW = $clog2(LOCK_WINDOWS + 1);
  localparam phase_t      K_RST = phase_t'(OS_RATIO / 2);
  localparam phase_t      K_MAX = phase_t'(OS_RATIO - 1);

  logic [OS_RATIO-1:0] s_q, s_d;
  logic                sp_q;
  logic                v1_q;
  logic [OS_RATIO-1:0] t_c;
  logic [HW-1:0]       hist_q [OS_RATIO];
  logic [HW-1:0]       hist_d [OS_RATIO];
  logic [HW-1:0]       best_c;
  logic [TW-1:0]       total_c;
  phase_t              e_c, target_c;
  phase_t              k_q, k_d, k_prev_q;
  logic [SW-1:0]       stab_q, stab_d, stab_inc_c;
  logic                lock_q, lock_d;
  logic [1:0]          dat_q, dat_d, cnt_q, cnt_d;

  // Stage 1 input: undo inversion of odd-numbered samples (raw bits 6,4,2,0)
  // and re-index so s[0] is the earliest sample.
  always_comb begin
    s_d = '0;
    for (int unsigned i = 0; i < OS_RATIO; i++) begin
      s_d[i] = os[OS_RATIO-1-i] ^ i[0];
    end
  end

  // Transition between consecutive samples, including across words.
  assign t_c = {s_q[OS_RATIO-1:1] ^ s_q[OS_RATIO-2:0], s_q[0] ^ sp_q};

  // Histogram restarts with this clock's transitions on the clock after window end.
  always_comb begin
    for (int unsigned i = 0; i < OS_RATIO; i++) begin
      hist_d[i] = (wend ? '0 : hist_q[i]) + HW'(t_c[i]);
    end
  end

  // Edge position = argmax (lowest index wins ties); eye centre half a UI away.
  always_comb begin
    best_c  = hist_q[0];
    e_c     = '0;
    total_c = '0;
    for (int unsigned i = 0; i < OS_RATIO; i++) begin
      total_c = total_c + TW'(hist_q[i]);
      if (hist_q[i] > best_c) begin
        best_c = hist_q[i];
        e_c    = phase_t'(i);
      end
    end
  end

  assign target_c   = e_c + phase_t'(OS_RATIO / 2);
  assign stab_inc_c = (stab_q < SW'(LOCK_WINDOWS)) ? stab_q + SW'(1) : stab_q;

  // Phase and lock update, once per window.
  always_comb begin
    k_d    = k_q;
    stab_d = stab_q;
    lock_d = lock_q;
    if (wend) begin
      if (total_c < TW'(MIN_EDGES)) begin
        stab_d = '0;
        lock_d = 1'b0;
      end else begin
        case (phase_step(target_c, k_q))
          STEP_HOLD: begin
            stab_d = stab_inc_c;
            lock_d = (stab_inc_c == SW'(LOCK_WINDOWS));
          end
          STEP_UP: begin
            k_d    = k_q + phase_t'(1);
            stab_d = '0;
            lock_d = 1'b0;
          end
          default: begin
            k_d    = k_q - phase_t'(1);
            stab_d = '0;
            lock_d = 1'b0;
          end
        endcase
      end
    end
`ifdef OVERSAMPLE_CDR_FORCE_PHASE_EN
    if (force_en) begin
      k_d    = force_k;
      stab_d = '0;
      lock_d = 1'b0;
    end
`endif
  end

  // Stage 2 output. A 7->0 wrap would resample the UI just emitted; a 0->7
  // wrap would skip the UI the old phase was about to take from this word.
  always_comb begin
    dat_d = 2'b00;
    cnt_d = CNT_NONE;
    if (v1_q) begin
      if (k_prev_q == K_MAX && k_q == '0) begin
        cnt_d = CNT_NONE;
      end else if (k_prev_q == '0 && k_q == K_MAX) begin
        cnt_d = CNT_TWO;
        dat_d = {s_q[0], s_q[OS_RATIO-1]};
      end else begin
        cnt_d = CNT_ONE;
        dat_d = {1'b0, s_q[k_q]};
      end
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      s_q      <= '0;
      sp_q     <= 1'b0;
      v1_q     <= 1'b0;
      k_q      <= K_RST;
      k_prev_q <= K_RST;
      stab_q   <= '0;
      lock_q   <= 1'b0;
      dat_q    <= '0;
      cnt_q    <= CNT_NONE;
      for (int unsigned i = 0; i < OS_RATIO; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      s_q      <= s_d;
      sp_q     <= s_q[OS_RATIO-1];
      v1_q     <= 1'b1;
      k_q      <= k_d;
      k_prev_q <= k_q;
      stab_q   <= stab_d;
      lock_q   <= lock_d;
      dat_q    <= dat_d;
      cnt_q    <= cnt_d;
      for (int unsigned i = 0; i < OS_RATIO; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign dat    = dat_q;
  assign cnt    = cnt_q;
  assign locked = lock_q;

endmodule

// File: rtl/oversample_cdr.sv
// Multi-channel 8x-oversampled CDR back end: NCH independent lanes sharing
// one histogram window counter.
// Optional feature macro: OVERSAMPLE_CDR_FORCE_PHASE_EN adds force_en/force_k.
// Ports:
//   c       clock (one UI per clock)
//   r       synchronous active-high reset
//   os      raw samples, channel n at os[8n+7:8n]
//   dat     recovered bits, channel n at dat[2n+1:2n], [2n+1] older
//   cnt     valid bit count per channel (0, 1 or 2)
//   locked  per-channel lock
module oversample_cdr
  import oversample_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned WIN_LOG2     = 8,
  parameter int unsigned MIN_EDGES    = 16,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic                    c,
  input  logic                    r,
  input  logic [OS_RATIO*NCH-1:0] os,
`ifdef OVERSAMPLE_CDR_FORCE_PHASE_EN
  input  logic [NCH-1:0]          force_en,
  input  logic [PH_W*NCH-1:0]     force_k,
`endif
  output logic [2*NCH-1:0]        dat,
  output logic [2*NCH-1:0]        cnt,
  output logic [NCH-1:0]          locked
);

  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
  logic                wend_q, wend_d;

  // Shared window counter; wend_q marks the clock after the last window clock.
  always_comb begin
    wcnt_d = wcnt_q + WIN_LOG2'(1);
    wend_d = (wcnt_q == '1);
  end

  always_ff @(posedge c) begin
    if (r) begin
      wcnt_q <= '0;
      wend_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wend_q <= wend_d;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    oversample_cdr_lane #(
      .WIN_LOG2     (WIN_LOG2),
      .MIN_EDGES    (MIN_EDGES),
      .LOCK_WINDOWS (LOCK_WINDOWS)
    ) u_lane (
      .c        (c),
      .r        (r),
      .wend     (wend_q),
      .os       (os[OS_RATIO*n +: OS_RATIO]),
`ifdef OVERSAMPLE_CDR_FORCE_PHASE_EN
      .force_en (force_en[n]),
      .force_k  (force_k[PH_W*n +: PH_W]),
`endif
      .dat      (dat[2*n +: 2]),
      .cnt      (cnt[2*n +: 2]),
      .locked   (locked[n])
    );
  end

endmodule

// File: tb/tb_oversample_cdr.sv
// Bench for oversample_cdr. Each channel runs its own directed scenario:
//   ch0 constant zero data, ch1 alternating bits with edge at 2 (k 4->6),
//   ch2 random data edge 4 (k 4->0 via 7->0 wrap) then edge 3 (0->7 wrap),
//   ch3 random data edge 0 (locks) then 15 edges per window (lock drops).
// Transmitted bits are queued per channel; a negedge monitor pops them as
// the DUT reports valid bits.
module tb_oversample_cdr;

  localparam int unsigned NCH   = 4;
  localparam int          WIN   = 256;
  localparam int          NPRE  = 15 * WIN + 50;
  localparam int          NPOST = 300;

  logic               c = 1'b0;
  logic               r = 1'b1;
  logic [8*NCH-1:0]   os = '0;
  logic [2*NCH-1:0]   dat;
  logic [2*NCH-1:0]   cnt;
  logic [NCH-1:0]     locked;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q [NCH][$];
  bit prev_b [NCH];
  int zero_seen [NCH];
  int two_seen [NCH];
  bit wrap_count_en = 1'b0;

  oversample_cdr #(
    .NCH          (NCH),
    .WIN_LOG2     (8),
    .MIN_EDGES    (16),
    .LOCK_WINDOWS (4)
  ) dut (
    .c      (c),
    .r      (r),
    .os     (os),
    .dat    (dat),
    .cnt    (cnt),
    .locked (locked)
  );

  always #5 c = ~c;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input int n, input logic got);
    bit e;
    if (exp_q[n].size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL bit_ch%0d: got bit %0d, required no bit (none pending)", n, got);
    end else begin
      e = exp_q[n].pop_front();
      check($sformatf("bit_ch%0d", n), int'(got), int'(e));
    end
  endtask

  // Monitor: consume recovered bits in stream order.
  always @(negedge c) begin
    if (!r) begin
      for (int n = 0; n < NCH; n++) begin
        case (cnt[2*n +: 2])
          2'd0: if (wrap_count_en) zero_seen[n]++;
          2'd1: pop_cmp(n, dat[2*n]);
          2'd2: begin
            if (wrap_count_en) two_seen[n]++;
            pop_cmp(n, dat[2*n+1]);
            pop_cmp(n, dat[2*n]);
          end
          default: check($sformatf("cnt_ch%0d", n), int'(cnt[2*n +: 2]), 1);
        endcase
      end
    end
  end

  // One UI per channel: samples before position e still carry the previous bit.
  task automatic gen_word(input int w);
    bit          b;
    int          e;
    logic [7:0]  raw;
    logic        si;
    for (int n = 0; n < NCH; n++) begin
      case (n)
        0: begin b = 1'b0; e = 0; end
        1: begin b = w[0]; e = 2; end
        2: begin b = 1'($urandom); e = (w >= 8*WIN + 10) ? 3 : 4; end
        default: begin
          e = 0;
          if (w < 5*WIN + 200) b = 1'($urandom);
          else if ((w % WIN) >= 100 && (w % WIN) <= 114) b = ~prev_b[n];
          else b = prev_b[n];
        end
      endcase
      raw = '0;
      for (int i = 0; i < 8; i++) begin
        si         = (i >= e) ? b : prev_b[n];
        raw[7 - i] = si ^ i[0];
      end
      os[8*n +: 8] = raw;
      exp_q[n].push_back(b);
      prev_b[n] = b;
    end
  endtask

  // Hand-derived lock expectation sampled mid-window m.
  function automatic int exp_lock(input int n, input int m);
    int v;
    case (n)
      1:       v = (m >= 6) ? 1 : 0;
      2:       v = (m == 8 || m >= 13) ? 1 : 0;
      3:       v = (m >= 4 && m <= 6) ? 1 : 0;
      default: v = 0;
    endcase
    return v;
  endfunction

  initial begin
    for (int n = 0; n < NCH; n++) begin
      prev_b[n]    = 1'b0;
      zero_seen[n] = 0;
      two_seen[n]  = 0;
    end
    repeat (3) @(posedge c);
    #1;
    check("rst_dat", int'(dat), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_locked", int'(locked), 0);
    r = 1'b0;

    for (int w = 0; w < NPRE; w++) begin
      gen_word(w);
      if (w == 4) wrap_count_en = 1'b1;
      if ((w % WIN) == 128) begin
        for (int n = 0; n < NCH; n++) begin
          check($sformatf("lock_ch%0d_win%0d", n, w / WIN), int'(locked[n]), exp_lock(n, w / WIN));
        end
      end
      @(posedge c);
      #1;
    end
    wrap_count_en = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      check($sformatf("cnt0_events_ch%0d", n), zero_seen[n], (n == 2) ? 1 : 0);
      check($sformatf("cnt2_events_ch%0d", n), two_seen[n], (n == 2) ? 1 : 0);
    end

    // Reset in the middle of a window.
    r = 1'b1;
    @(posedge c);
    #1;
    check("midrst_dat", int'(dat), 0);
    check("midrst_cnt", int'(cnt), 0);
    check("midrst_locked", int'(locked), 0);
    for (int n = 0; n < NCH; n++) begin
      exp_q[n].delete();
      prev_b[n] = 1'b0;
    end
    r = 1'b0;

    for (int w = 0; w < NPOST; w++) begin
      gen_word(w);
      if (w == 128) begin
        for (int n = 0; n < NCH; n++) begin
          check($sformatf("post_lock_ch%0d", n), int'(locked[n]), 0);
        end
      end
      @(posedge c);
      #1;
    end
    // Two words are still in the pipeline; anything more means bits were dropped.
    for (int n = 0; n < NCH; n++) begin
      check($sformatf("pending_ch%0d", n), int'(exp_q[n].size()), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
